// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared parameters and loader state encodings
package program_loader_pkg;

  localparam int INST_WIDTH        = 16;
  localparam int ADDR_WIDTH        = 8;
  localparam int LOADER_BYTE_WIDTH = 8;

  localparam logic [2:0] LD_IDLE  = 3'd0;
  localparam logic [2:0] LD_LEN   = 3'd1;
  localparam logic [2:0] LD_BYTES = 3'd2;
  localparam logic [2:0] LD_WRITE = 3'd3;
  localparam logic [2:0] LD_CHECK = 3'd4;
  localparam logic [2:0] LD_DONE  = 3'd5;
  localparam logic [2:0] LD_ERROR = 3'd6;

endpackage

// File: rtl/program_loader_inst_assembler.sv
// rtl/program_loader_inst_assembler.sv - byte-to-word assembly with running XOR checksum
module program_loader_inst_assembler
  import program_loader_pkg::*;
#(
  parameter int INST_WIDTH = program_loader_pkg::INST_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         shift_en,
  input  logic [LOADER_BYTE_WIDTH-1:0] stream_byte,
  output logic [INST_WIDTH-1:0]        word,
  output logic                         last_byte,
  output logic [LOADER_BYTE_WIDTH-1:0] chk
);

  localparam int BYTES_PER_INST = INST_WIDTH / LOADER_BYTE_WIDTH;
  localparam int IDX_WIDTH      = (BYTES_PER_INST > 1) ? $clog2(BYTES_PER_INST) : 1;

  logic [IDX_WIDTH-1:0] idx;

  // High while the byte about to be accepted completes the current word
  assign last_byte = (idx == IDX_WIDTH'(BYTES_PER_INST - 1));

  // Shift bytes in MSB first; the index wraps per word, the checksum spans the whole image
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
      chk  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
      chk  <= '0;
    end else if (shift_en) begin
      word <= (word << LOADER_BYTE_WIDTH) | INST_WIDTH'(stream_byte);
      chk  <= chk ^ stream_byte;
      idx  <= last_byte ? '0 : idx + IDX_WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into instruction RAM and releases the processor
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INST_WIDTH = program_loader_pkg::INST_WIDTH,
  parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         In_Valid,
  input  logic [LOADER_BYTE_WIDTH-1:0] In_Byte,
  output logic                         In_Ready,
  output logic                         Ram_Inst_Write,
  output logic [ADDR_WIDTH-1:0]        Inst_Addr,
  output logic [INST_WIDTH-1:0]        Ram_Inst_In,
  output logic                         Proc_Reset,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);

  logic [2:0]                   state;
  logic [ADDR_WIDTH-1:0]        remaining;
  logic                         handshake;
  logic                         accept_start;
  logic                         last_byte;
  logic [LOADER_BYTE_WIDTH-1:0] chk;

  assign handshake    = In_Valid && In_Ready;
  assign accept_start = Start && (state == LD_IDLE || state == LD_DONE || state == LD_ERROR);

  // The assembled word register doubles as the RAM data output; it is frozen while in WRITE
  program_loader_inst_assembler #(
    .INST_WIDTH(INST_WIDTH)
  ) u_inst_assembler (
    .clk        (Clk),
    .rst        (Reset),
    .clear      (accept_start),
    .shift_en   (handshake && state == LD_BYTES),
    .stream_byte(In_Byte),
    .word       (Ram_Inst_In),
    .last_byte  (last_byte),
    .chk        (chk)
  );

  // Ready is a pure function of state so it never combinationally follows In_Valid
  always_comb begin
    In_Ready = 1'b0;
    case (state)
      LD_LEN, LD_BYTES, LD_CHECK: In_Ready = 1'b1;
      default:                    In_Ready = 1'b0;
    endcase
  end

  // Load sequencer; Inst_Addr is the address counter itself, advanced as WRITE ends
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= LD_IDLE;
      remaining      <= '0;
      Inst_Addr      <= '0;
      Ram_Inst_Write <= 1'b0;
      Proc_Reset     <= 1'b1;
      Busy           <= 1'b0;
      Done           <= 1'b0;
      Error          <= 1'b0;
    end else begin
      Ram_Inst_Write <= 1'b0;
      case (state)
        LD_IDLE, LD_DONE, LD_ERROR: begin
          if (accept_start) begin
            state      <= LD_LEN;
            Busy       <= 1'b1;
            Done       <= 1'b0;
            Error      <= 1'b0;
            Proc_Reset <= 1'b1;
            Inst_Addr  <= '0;
          end
        end
        LD_LEN: begin
          if (handshake) begin
            remaining <= In_Byte[ADDR_WIDTH-1:0];
            state     <= (In_Byte[ADDR_WIDTH-1:0] == '0) ? LD_CHECK : LD_BYTES;
          end
        end
        LD_BYTES: begin
          if (handshake && last_byte) begin
            state          <= LD_WRITE;
            Ram_Inst_Write <= 1'b1;
          end
        end
        LD_WRITE: begin
          Inst_Addr <= Inst_Addr + ADDR_WIDTH'(1);
          remaining <= remaining - ADDR_WIDTH'(1);
          state     <= (remaining == ADDR_WIDTH'(1)) ? LD_CHECK : LD_BYTES;
        end
        LD_CHECK: begin
          if (handshake) begin
            Busy <= 1'b0;
            if (In_Byte == chk) begin
              state      <= LD_DONE;
              Done       <= 1'b1;
              Proc_Reset <= 1'b0;
            end else begin
              state <= LD_ERROR;
              Error <= 1'b1;
            end
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream stage of the processor top level.
- Receives a program as a byte stream over a valid/ready handshake and assembles the bytes into instruction words.
- Burns each word into instruction RAM through the processor's instruction-write port (Ram_Inst_Write, Inst_Addr, Ram_Inst_In).
- Holds the processor in reset until the whole image has loaded and passed its checksum, then releases it.

Parameters:
- INST_WIDTH, 16, instruction word width; must equal the shared INST_WIDTH and be a multiple of 8.
- ADDR_WIDTH, 8, instruction address width; must equal the shared ADDR_WIDTH and be no more than 8.
- BYTES_PER_INST, INST_WIDTH/8, number of stream bytes per instruction (derived; do not override).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  request to begin a load; sampled only in IDLE, DONE and ERROR.
- In_Valid  in  1  In_Byte carries a valid byte.
- In_Byte  in  8  stream byte.
- In_Ready  out  1  loader accepts a byte; transfer occurs when In_Valid && In_Ready at the rising edge.
- Ram_Inst_Write  out  1  one-cycle write strobe to instruction RAM.
- Inst_Addr  out  ADDR_WIDTH  write address.
- Ram_Inst_In  out  INST_WIDTH  instruction word to write.
- Proc_Reset  out  1  drives the processor's Reset input; high holds the processor.
- Busy  out  1  a load is in progress.
- Done  out  1  load completed with a good checksum.
- Error  out  1  checksum mismatch.

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE;
  - Proc_Reset=1;
  - Ram_Inst_Write, In_Ready, Busy, Done, Error = 0;
  - Inst_Addr, Ram_Inst_In, internal count, byte index and checksum = 0.
- Reset asserted mid-load aborts the load. RAM contents already written are left as they are; there is no rollback.
- Stream format: COUNT byte (N); then N×BYTES_PER_INST instruction bytes, MSB first; then CHK byte = XOR of all instruction bytes (COUNT is excluded).
- In_Ready is a Moore output of state only and never depends on In_Valid. All other outputs are registered.
- States:
  - IDLE: In_Ready=0. Start=1 → LEN. On that same edge: Busy=1, Done=0, Error=0, Proc_Reset=1, address counter=0, checksum=0.
  - LEN: In_Ready=1. On handshake, latch N = In_Byte[ADDR_WIDTH-1:0]. N=0 → CHECK; otherwise → BYTES with byte index=0.
  - BYTES: In_Ready=1. Each handshake shifts the byte into the assembly register (MSB first) and sets checksum ^= byte. The handshake of byte BYTES_PER_INST-1 → WRITE.
  - WRITE: In_Ready=0. Ram_Inst_Write=1 for exactly this one cycle, with Inst_Addr = address counter and Ram_Inst_In = the assembled word, both stable for the whole cycle. At the end of the cycle: address counter+1, remaining−1. If remaining reaches 0 → CHECK; otherwise → BYTES.
  - CHECK: In_Ready=1. On handshake:
    - In_Byte == checksum → DONE: Done=1, Busy=0, Proc_Reset=0 on that edge.
    - Otherwise → ERROR: Error=1, Busy=0, Proc_Reset stays 1.
  - DONE / ERROR: hold all flags. Start=1 → LEN, with the same edge effects as from IDLE. This means Proc_Reset rises on the same edge in which a reload from DONE starts.
- Start while Busy=1 is ignored.
- Cycles with In_Valid=0 do not advance state, byte index or checksum.
- Latency:
  - Start → In_Ready=1 takes one cycle.
  - The final byte's handshake of an instruction at edge k → Ram_Inst_Write high during cycle k+1.
  - Peak throughput is one instruction per BYTES_PER_INST+1 cycles.
- Address wrap: N ≤ 2^ADDR_WIDTH−1, so the address counter never wraps within a load. N=255 with ADDR_WIDTH=8 writes addresses 0..254.
- Ram_Inst_Write is never asserted outside WRITE.

Decomposition:
- Shared parameters header:
  - INST_WIDTH and ADDR_WIDTH (existing);
  - new LOADER_BYTE_WIDTH=8;
  - new loader state encodings LD_IDLE, LD_LEN, LD_BYTES, LD_WRITE, LD_CHECK, LD_DONE, LD_ERROR (3-bit).
- One sub-module is natural: inst_assembler. It contains the byte shift register, the byte index counter and the running XOR checksum, with inputs shift_en and clear, and outputs word, last_byte and chk.
- The FSM, the address/remaining counters and the output registers stay in program_loader.

Test Plan:
- Good load: Start; stream 0x02,0x12,0x34,0xAB,0xCD,0x40 with In_Valid held high → writes addr0=0x1234 and addr1=0xABCD, each with a one-cycle strobe; Done=1, Error=0, Busy=0, Proc_Reset falls on the CHK edge.
- Bad checksum: same stream but CHK=0x41 → both writes occur; Error=1, Done=0, Proc_Reset stays 1.
- Empty image: Start; stream 0x00,0x00 → no Ram_Inst_Write pulses; Done=1, Proc_Reset=0.
- Backpressure, gaps and ignored Start: insert In_Valid=0 gaps of 1–3 cycles between bytes of the good-load stream and pulse Start mid-load → identical writes and result; no extra writes.
- Reload: after a good load, Start; stream 0x01,0xBE,0xEF,0x51 → Proc_Reset=1 and Done=0 on the Start edge; write addr0=0xBEEF; Done=1 again.
- Reset mid-operation: assert Reset after the second instruction byte → outputs return to reset values immediately (asynchronously), state IDLE; no write was issued for the partial word; a following good load succeeds.
